// File: rtl/div_restaura_uc.sv
// Sequential unsigned restoring divider with a Start/Done handshake.
// {A,Q} shifts left one bit per clock and produces one quotient bit per iteration.
//
// state | meaning
// IDLE  | waiting for Start; last Cociente/Resto/DivCero held
// ITER  | one shift/subtract/restore step per clock, N steps
// DONE  | one-cycle Done pulse, then back to IDLE unconditionally
module div_restaura_uc #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] Dividendo,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Cociente,
  output logic [N-1:0] Resto,
  output logic         Busy,
  output logic         Done,
  output logic         DivCero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t        state;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;

  logic [N:0]    a_sh;
  logic [N:0]    d;
  logic [N:0]    a_next;
  logic [N-1:0]  q_next;
  logic          fits;

  // A stays below M between iterations, so A[N] is always clear; folding it
  // into the fit decision keeps a corrupted A from ever producing a 1 bit.
  always_comb begin
    a_sh   = {a[N-1:0], q[N-1]};
    d      = a_sh - {1'b0, m};
    fits   = ~d[N] & ~a[N];
    a_next = fits ? d : a_sh;
    q_next = {q[N-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state    <= IDLE;
      a        <= '0;
      q        <= '0;
      m        <= '0;
      cnt      <= '0;
      Cociente <= '0;
      Resto    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      DivCero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          Busy <= 1'b0;
          if (Start) begin
            if (Divisor != '0) begin
              a       <= '0;
              q       <= Dividendo;
              m       <= Divisor;
              cnt     <= CNT_LOAD;
              DivCero <= 1'b0;
              Busy    <= 1'b1;
              state   <= ITER;
            end else begin
              Cociente <= '1;
              Resto    <= Dividendo;
              DivCero  <= 1'b1;
              Done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        ITER: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            Cociente <= q_next;
            Resto    <= a_next[N-1:0];
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_restaura_uc.md
Name: div_restaura_uc

Overview:
- Sequential unsigned restoring divider with its own control unit. It is the division counterpart of the Booth multiplier datapath.
- The remainder/quotient pair {A,Q} shifts LEFT one bit per iteration, where the multiplier's accumulator shifts arithmetically right.
- It sits beside the multiplier in the arithmetic unit and shares the same Start/Done style of handshake with the top-level control.

Parameters:
- N, 4, operand width in bits (dividend, divisor, quotient and remainder). Legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- Start  input  1  request a division; sampled only in state IDLE.
- Dividendo  input  N  unsigned dividend; captured when Start is accepted.
- Divisor  input  N  unsigned divisor; captured when Start is accepted.
- Cociente  output  N  quotient, registered.
- Resto  output  N  remainder, registered.
- Busy  output  1  high while an iteration is in progress (state ITER).
- Done  output  1  one-cycle pulse: result valid (state DONE).
- DivCero  output  1  divide-by-zero flag; valid with Done; held until the next accepted Start.

Behaviour:
- Reset (Reset=0 at an edge):
  - state -> IDLE; iteration counter -> 0.
  - Internal registers A (N+1 bits), Q (N bits) and M (N bits) -> 0.
  - Cociente, Resto, Busy, Done and DivCero all -> 0.
  - Reset has priority over every other event, including mid-iteration. The partial result is discarded.
- States: IDLE, ITER, DONE.
- IDLE:
  - Start=1 at an edge with Divisor!=0:
    - Load A=0, Q=Dividendo, M=Divisor, counter=N.
    - Clear DivCero.
    - Go to ITER.
  - Start=1 at an edge with Divisor==0:
    - Go directly to DONE with DivCero=1.
    - Cociente = all ones (2^N-1); Resto = Dividendo.
  - Start=0: stay in IDLE; outputs hold their previous values.
- ITER (one iteration per clock):
  - Shift {A,Q} left by 1; Q[0] temporarily 0.
  - Compute D = A_shifted - {0,M} at N+1 bits.
  - If D[N]==0: A=D and Q[0]=1. Otherwise A is kept (restored) and Q[0]=0.
  - Decrement the counter.
  - When the counter reaches 0 after this iteration:
    - Load Cociente=Q and Resto=A[N-1:0].
    - Go to DONE.
- DONE:
  - Done=1 and Busy=0 for exactly one cycle.
  - Then go to IDLE unconditionally. Start seen in DONE is ignored and must be reasserted in IDLE.
- Latency:
  - Start accepted at edge 0.
  - Iterations run at edges 1..N.
  - Done is high in the cycle following edge N, i.e. N+1 cycles after acceptance (5 for N=4).
  - Divide-by-zero case: Done is high in the cycle following edge 0.
- Busy is high exactly in ITER cycles (N cycles).
- Start is ignored while Busy=1; operands changing during ITER have no effect.
- Cociente and Resto hold their values from DONE through IDLE until the next completion. They do not change during ITER.
- Arithmetic invariant at completion with Divisor!=0:
  - Dividendo == Cociente*Divisor + Resto.
  - Resto < Divisor.
- Start held high continuously: a new division is accepted on the first IDLE edge after DONE. Back-to-back throughput is therefore N+2 cycles per operation.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> Cociente=0, Resto=0, Busy=0, Done=0, DivCero=0. Holding Start=0 for 10 cycles keeps them unchanged.
- N=4, Dividendo=13, Divisor=3, Start pulse -> Busy high for 4 cycles. Done pulses 5 cycles after acceptance with Cociente=4, Resto=1, DivCero=0. Outputs hold after Done.
- Dividendo=2, Divisor=9 -> Cociente=0, Resto=2.
- Dividendo=15, Divisor=1 -> Cociente=15, Resto=0.
- Exhaustive sweep of all 16x15 non-zero-divisor pairs -> every result matches the invariant.
- Dividendo=7, Divisor=0 -> Done one cycle after acceptance with DivCero=1, Cociente=15, Resto=7, and Busy never asserted. A following 9/2 clears DivCero and gives Cociente=4, Resto=1.
- Start 13/3, then at the 2nd ITER cycle pulse Start with 9/2 and change the operands -> request ignored, result still 4/1.
- Start 13/3, then assert Reset=0 at the 2nd ITER cycle -> next cycle IDLE with all outputs 0. A subsequent 14/4 gives Cociente=3, Resto=2.
- Start held high for 20 cycles with 13/3 -> Done pulses every 6 cycles, each with result 4/1.
